// File: rtl/bsram_byte_en_multiport_pkg.sv
// Shared constants for the multi-read-port byte-enable BSRAM: clear FSM
// state encoding and the lane count helper.
package bsram_byte_en_multiport_pkg;

  localparam logic [0:0] CLEARING = 1'b0;
  localparam logic [0:0] READY    = 1'b1;

  // NUM_LANES for a given word/lane geometry.
  function automatic int numLanes(input int dataWidth, input int byteWidth);
    return dataWidth / byteWidth;
  endfunction

endpackage

// File: rtl/bsram_read_port_bypass.sv
// One read port: write-address compare, per-lane write-first merge with the
// stored word, and an optional output register.
module bsram_read_port_bypass
  import bsram_byte_en_multiport_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ready,
  input  logic                             readEnable,
  input  logic [ADDR_WIDTH-1:0]            readAddress,
  input  logic [DATA_WIDTH-1:0]            storedWord,
  input  logic                             writeEnable,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] writeByteEnable,
  input  logic [ADDR_WIDTH-1:0]            writeAddress,
  input  logic [DATA_WIDTH-1:0]            writeData,
  output logic [DATA_WIDTH-1:0]            readData,
  output logic                             readValid
);

  localparam int NUM_LANES = numLanes(DATA_WIDTH, BYTE_WIDTH);

  logic                  bypassHit;
  logic                  access;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] word;

  assign bypassHit = writeEnable & ready & (readAddress == writeAddress);
  assign access    = ready & readEnable;

  // Only the lanes being written are taken from writeData; the rest stay stored.
  always_comb begin
    merged = storedWord;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bypassHit && writeByteEnable[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = writeData[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign word = access ? merged : '0;

  generate
    if (READ_LATENCY == 0) begin : gComb
      assign readData  = word;
      assign readValid = access;
    end else begin : gReg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          readData  <= '0;
          readValid <= 1'b0;
        end else begin
          readData  <= word;
          readValid <= access;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/bsram_byte_en_multiport.sv
// Byte-masked single-write / multi-read scratch RAM with write-to-read bypass,
// configurable read latency and a hardware zeroing sweep.
module bsram_byte_en_multiport
  import bsram_byte_en_multiport_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int NUM_READ_PORTS  = 2,
  parameter int READ_LATENCY    = 0,
  parameter int CLEAR_ON_RESET  = 1,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 clear,
  output logic                                 ready,
  input  logic [NUM_READ_PORTS-1:0]            readEnable,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] readAddress,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] readData,
  output logic [NUM_READ_PORTS-1:0]            readValid,
  input  logic                                 writeEnable,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     writeByteEnable,
  input  logic [ADDR_WIDTH-1:0]                writeAddress,
  input  logic [DATA_WIDTH-1:0]                writeData,
  input  logic                                 scan
);

  localparam int NUM_LANES = numLanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] sram [MEM_DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clearAddr;
  logic [31:0]           cycles;
  logic signed [32:0]    cycleSigned;

  assign ready = (state == READY);

  // Clear FSM; clear is only looked at while READY, and the sweep ends on the last address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEARING : READY;
      clearAddr <= '0;
      cycles    <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (state == CLEARING) begin
        clearAddr <= clearAddr + 1'b1;
        if (&clearAddr) state <= READY;
      end else if (clear) begin
        state     <= CLEARING;
        clearAddr <= '0;
      end
    end
  end

  // The array has no reset; the sweep owns the write port while clearing.
  always_ff @(posedge clock) begin
    if (state == CLEARING) begin
      sram[clearAddr] <= '0;
    end else if (writeEnable) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (writeByteEnable[i]) begin
          sram[writeAddress][i*BYTE_WIDTH +: BYTE_WIDTH] <= writeData[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read handshake: no backpressure; readValid[p] qualifies readData[p] in the
  // cycle it is presented, and both are zero whenever ready=0 or the port is idle.
  generate
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gReadPort
      bsram_read_port_bypass #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BYTE_WIDTH  (BYTE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY)
      ) uReadPort (
        .clock          (clock),
        .reset          (reset),
        .ready          (ready),
        .readEnable     (readEnable[p]),
        .readAddress    (readAddress[p*ADDR_WIDTH +: ADDR_WIDTH]),
        .storedWord     (sram[readAddress[p*ADDR_WIDTH +: ADDR_WIDTH]]),
        .writeEnable    (writeEnable),
        .writeByteEnable(writeByteEnable),
        .writeAddress   (writeAddress),
        .writeData      (writeData),
        .readData       (readData[p*DATA_WIDTH +: DATA_WIDTH]),
        .readValid      (readValid[p])
      );
    end
  endgenerate

  assign cycleSigned = {1'b0, cycles};

  always_ff @(posedge clock) begin
    if (scan && cycleSigned >= 33'(SCAN_CYCLES_MIN) && cycleSigned <= 33'(SCAN_CYCLES_MAX)) begin
      $display("core=%0d cycle=%0d state=%s clearAddr=%0d we=%b wbe=%b wa=%h wd=%h",
               CORE, cycles, (state == READY) ? "READY" : "CLEARING", clearAddr,
               writeEnable, writeByteEnable, writeAddress, writeData);
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        $display("  core=%0d port=%0d re=%b ra=%h rd=%h rv=%b", CORE, p, readEnable[p],
                 readAddress[p*ADDR_WIDTH +: ADDR_WIDTH],
                 readData[p*DATA_WIDTH +: DATA_WIDTH], readValid[p]);
      end
    end
  end

endmodule

// File: tb/tb_bsram_byte_en_multiport.sv
// Directed bench: one latency-0 and one latency-1 instance share all inputs;
// combinational results are sampled at negedge, registered ones just after posedge.
module tb_bsram_byte_en_multiport;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        scan;
  logic [1:0]  readEnable;
  logic [7:0]  readAddress;
  logic        writeEnable;
  logic [3:0]  writeByteEnable;
  logic [3:0]  writeAddress;
  logic [31:0] writeData;

  logic        ready0, ready1;
  logic [63:0] readData0, readData1;
  logic [1:0]  readValid0, readValid1;

  int total = 0;
  int bad = 0;
  int n;
  logic [31:0] exp_q[$];

  bsram_byte_en_multiport #(.ADDR_WIDTH(4), .READ_LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready0),
    .readEnable(readEnable), .readAddress(readAddress), .readData(readData0),
    .readValid(readValid0), .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
    .writeAddress(writeAddress), .writeData(writeData), .scan(scan)
  );

  bsram_byte_en_multiport #(.ADDR_WIDTH(4), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready1),
    .readEnable(readEnable), .readAddress(readAddress), .readData(readData1),
    .readValid(readValid1), .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
    .writeAddress(writeAddress), .writeData(writeData), .scan(scan)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One READY cycle: latency-0 results at negedge, latency-1 results after the edge.
  task automatic runCycle(input string tag, input logic [1:0] re, input logic [3:0] ra0,
                          input logic [3:0] ra1, input logic we, input logic [3:0] wbe,
                          input logic [3:0] wa, input logic [31:0] wd,
                          input logic [31:0] e0, input logic [31:0] e1);
    readEnable      = re;
    readAddress     = {ra1, ra0};
    writeEnable     = we;
    writeByteEnable = wbe;
    writeAddress    = wa;
    writeData       = wd;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    @(negedge clock);
    check({tag, ".l0.d0"}, readData0[31:0], e0);
    check({tag, ".l0.d1"}, readData0[63:32], e1);
    check({tag, ".l0.v"}, 32'(readValid0), 32'(re));
    @(posedge clock);
    #1;
    check({tag, ".l1.d0"}, readData1[31:0], exp_q.pop_front());
    check({tag, ".l1.d1"}, readData1[63:32], exp_q.pop_front());
    check({tag, ".l1.v"}, 32'(readValid1), 32'(re));
    writeEnable = 1'b0;
    readEnable  = 2'b00;
  endtask

  // Counts edges until ready rises, checking both instances stay silent meanwhile.
  task automatic waitSweep(input string tag);
    n = 0;
    while (ready0 !== 1'b1 && n < 100) begin
      #1;
      check({tag, ".l0.v"}, 32'(readValid0), 32'd0);
      check({tag, ".l0.d"}, readData0[31:0] | readData0[63:32], 32'd0);
      check({tag, ".l1.v"}, 32'(readValid1), 32'd0);
      check({tag, ".l1.d"}, readData1[31:0] | readData1[63:32], 32'd0);
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, ".cycles"}, 32'(n), 32'd16);
    check({tag, ".ready1"}, 32'(ready1), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    scan = 1'b0;
    readEnable = 2'b00;
    readAddress = '0;
    writeEnable = 1'b0;
    writeByteEnable = '0;
    writeAddress = '0;
    writeData = '0;

    #2;
    check("rst.ready0", 32'(ready0), 32'd0);
    check("rst.ready1", 32'(ready1), 32'd0);
    check("rst.l1.v", 32'(readValid1), 32'd0);
    check("rst.l1.d", readData1[31:0], 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    readEnable = 2'b11;
    waitSweep("init");
    readEnable = 2'b00;

    for (int a = 0; a < 16; a++) begin
      runCycle("zero", 2'b11, 4'(a), 4'(15 - a), 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    end

    // Byte-masked overwrite of a full word.
    runCycle("wr3a", 2'b00, 4'h0, 4'h0, 1'b1, 4'b1111, 4'h3, 32'hDEADBEEF, 32'h0, 32'h0);
    runCycle("wr3b", 2'b00, 4'h0, 4'h0, 1'b1, 4'b0101, 4'h3, 32'h11223344, 32'h0, 32'h0);
    runCycle("rd3", 2'b11, 4'h3, 4'h3, 1'b0, 4'h0, 4'h0, 32'h0, 32'hDE22BE44, 32'hDE22BE44);

    // Same-cycle lane-merge bypass on both ports.
    runCycle("wr5", 2'b00, 4'h0, 4'h0, 1'b1, 4'b1111, 4'h5, 32'h12345678, 32'h0, 32'h0);
    runCycle("byp5", 2'b11, 4'h5, 4'h5, 1'b1, 4'b0011, 4'h5, 32'hAABBCCDD, 32'h1234CCDD, 32'h1234CCDD);
    runCycle("rd5", 2'b11, 4'h5, 4'h3, 1'b0, 4'h0, 4'h0, 32'h0, 32'h1234CCDD, 32'hDE22BE44);
    runCycle("byp5b", 2'b10, 4'h5, 4'h5, 1'b1, 4'b1100, 4'h5, 32'h99887766, 32'h0, 32'h9988CCDD);

    // Port 1 idle while port 0 reads.
    runCycle("p1off", 2'b01, 4'h3, 4'h5, 1'b0, 4'h0, 4'h0, 32'h0, 32'hDE22BE44, 32'h0);

    // Clear request with writes attempted during the sweep.
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check("clr.ready0", 32'(ready0), 32'd0);
    readEnable = 2'b11;
    readAddress = 8'h00;
    writeEnable = 1'b1;
    writeByteEnable = 4'hF;
    writeAddress = 4'h0;
    writeData = 32'hFFFFFFFF;
    waitSweep("clr");
    writeEnable = 1'b0;
    readEnable = 2'b00;
    for (int a = 0; a < 16; a++) begin
      runCycle("clrd", 2'b11, 4'(a), 4'(a ^ 5), 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    end

    // Reset landing in the middle of a sweep restarts it from address 0.
    runCycle("wr4", 2'b00, 4'h0, 4'h0, 1'b1, 4'hF, 4'h4, 32'hCAFEF00D, 32'h0, 32'h0);
    runCycle("wrC", 2'b00, 4'h0, 4'h0, 1'b1, 4'hF, 4'hC, 32'h0BADF00D, 32'h0, 32'h0);
    runCycle("rd4", 2'b11, 4'h4, 4'hC, 1'b0, 4'h0, 4'h0, 32'h0, 32'hCAFEF00D, 32'h0BADF00D);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    readEnable = 2'b11;
    readAddress = {4'hC, 4'h4};
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midrst.ready0", 32'(ready0), 32'd0);
    check("midrst.l1.v", 32'(readValid1), 32'd0);
    check("midrst.l1.d", readData1[31:0] | readData1[63:32], 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    waitSweep("midrst");
    readEnable = 2'b00;
    runCycle("rd4z", 2'b11, 4'h4, 4'hC, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
